// File: rtl/deser_align.sv
// deser_align
// -----------------------------------------------------------------------------
// Single-clock 1:N deserializer with word-boundary alignment. One serial bit is
// sampled per enabled clock and DATA_WIDTH-bit words are assembled with the
// first-received bit in the MSB. Each completed word is presented on DOUT with
// a one-cycle DVALID strobe.
//
// Word boundary alignment:
//   - Default build: manual. Every enabled cycle with BITSLIP=1 moves the word
//     boundary one bit later.
//   - With DESER_AUTO_ALIGN_EN defined: a SEARCH/VERIFY/LOCKED state machine
//     hunts for the COMMA pattern at any bit position. BITSLIP is ignored in
//     this build.
//
// Parameters:
//   DATA_WIDTH  word width, 2..8
//   COMMA       alignment pattern, only the low DATA_WIDTH bits are used
//   LOCK_COUNT  on-boundary comma words needed to declare lock, 1..15
//   TIMEOUT     consecutive non-comma words that drop lock, 1..65535
//
// Ports:
//   CLK       sole clock, rising edge
//   RST       asynchronous active-high reset
//   DIN       serial data bit, sampled when CE=1
//   CE        bit enable; CE=0 freezes all state, DVALID reads 0
//   BITSLIP   manual slip request (level, one slip per CE=1 cycle)
//   DOUT      last assembled word, held between strobes
//   DVALID    one-cycle strobe marking a DOUT update
//   IS_COMMA  DOUT equals COMMA, only asserted together with DVALID
//   LOCKED    alignment state machine is in LOCKED
//   SLIP_CNT  accepted manual slips modulo DATA_WIDTH
// -----------------------------------------------------------------------------
module deser_align #(
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         LOCK_COUNT = 4,
  parameter int         TIMEOUT    = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  DIN,
  input  logic                  CE,
  input  logic                  BITSLIP,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  DVALID,
  output logic                  IS_COMMA,
  output logic                  LOCKED,
  output logic [2:0]            SLIP_CNT
);

  localparam logic [DATA_WIDTH-1:0] COMMA_W    = COMMA[DATA_WIDTH-1:0];
  localparam logic [2:0]            LAST_PHASE = 3'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-2:0] sr_q, sr_d;
  logic [2:0]            phase_q, phase_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dvalid_q, dvalid_d;
  logic                  is_comma_q, is_comma_d;

  // The candidate word always includes the bit arriving this cycle, so a word
  // completes on the same edge that samples its last bit.
  logic [DATA_WIDTH-1:0] w;
  logic                  w_is_comma;
  logic                  at_last;

  assign w          = {sr_q, DIN};
  assign w_is_comma = (w == COMMA_W);
  assign at_last    = (phase_q == LAST_PHASE);

`ifdef DESER_AUTO_ALIGN_EN

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  localparam logic [3:0]  LOCK_CNT_W = 4'(LOCK_COUNT);
  localparam logic [15:0] TIMEOUT_W  = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic [3:0]  hit_q, hit_d;
  logic [15:0] miss_q, miss_d;
  logic        search_hit;
  logic        locked_o;

  // Manual slipping does not exist in this build.
  logic unused_bitslip;
  assign unused_bitslip = BITSLIP;
  assign SLIP_CNT       = 3'd0;

  // In SEARCH a comma at any bit position realigns the word boundary to it.
  assign search_hit = CE && (state_q == ST_SEARCH) && w_is_comma;

  // Datapath: a search hit forces an early emission and restarts the phase.
  always_comb begin
    sr_d       = sr_q;
    phase_d    = phase_q;
    dout_d     = dout_q;
    dvalid_d   = 1'b0;
    is_comma_d = 1'b0;
    if (CE) begin
      sr_d = w[DATA_WIDTH-2:0];
      if (search_hit || at_last) begin
        dout_d     = w;
        dvalid_d   = 1'b1;
        is_comma_d = w_is_comma;
        phase_d    = 3'd0;
      end else begin
        phase_d = phase_q + 3'd1;
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_SEARCH;
      hit_q   <= 4'd0;
      miss_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state logic. Outside SEARCH only on-boundary words count: a comma
  // word is a hit and clears the miss run, any other word extends the run.
  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    case (state_q)
      ST_SEARCH: begin
        if (search_hit) begin
          hit_d   = 4'd1;
          miss_d  = 16'd0;
          state_d = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
        end
      end
      ST_VERIFY, ST_LOCKED: begin
        if (CE && at_last) begin
          if (w_is_comma) begin
            miss_d = 16'd0;
            if (state_q == ST_VERIFY) begin
              hit_d = hit_q + 4'd1;
              if (hit_q + 4'd1 == LOCK_CNT_W) begin
                state_d = ST_LOCKED;
              end
            end
          end else if (miss_q + 16'd1 == TIMEOUT_W) begin
            state_d = ST_SEARCH;
            hit_d   = 4'd0;
            miss_d  = 16'd0;
          end else begin
            miss_d = miss_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = ST_SEARCH;
        hit_d   = 4'd0;
        miss_d  = 16'd0;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    locked_o = (state_q == ST_LOCKED);
  end

  assign LOCKED = locked_o;

`else

  logic [2:0] slip_q, slip_d;

  // Datapath with manual slip. A slip keeps shifting but holds the phase, so
  // the word window drops its oldest bit; at the last phase this defers the
  // emission by one bit.
  always_comb begin
    sr_d       = sr_q;
    phase_d    = phase_q;
    dout_d     = dout_q;
    dvalid_d   = 1'b0;
    is_comma_d = 1'b0;
    slip_d     = slip_q;
    if (CE) begin
      sr_d = w[DATA_WIDTH-2:0];
      if (BITSLIP) begin
        slip_d = (slip_q == LAST_PHASE) ? 3'd0 : slip_q + 3'd1;
      end else if (at_last) begin
        dout_d     = w;
        dvalid_d   = 1'b1;
        is_comma_d = w_is_comma;
        phase_d    = 3'd0;
      end else begin
        phase_d = phase_q + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slip_q <= 3'd0;
    end else begin
      slip_q <= slip_d;
    end
  end

  assign SLIP_CNT = slip_q;
  assign LOCKED   = 1'b0;

`endif

  // Shared word-assembly registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr_q       <= '0;
      phase_q    <= 3'd0;
      dout_q     <= '0;
      dvalid_q   <= 1'b0;
      is_comma_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      phase_q    <= phase_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
      is_comma_q <= is_comma_d;
    end
  end

  assign DOUT     = dout_q;
  assign DVALID   = dvalid_q;
  assign IS_COMMA = is_comma_q;

endmodule

// File: tb/tb_deser_align.sv
// tb_deser_align
// -----------------------------------------------------------------------------
// Self-checking bench for deser_align (DATA_WIDTH=8, COMMA=8'hBC, LOCK_COUNT=4,
// TIMEOUT=16). A queue-based reference model predicts every output each cycle;
// directed scenarios additionally pin hand-computed values. Build with
// DESER_AUTO_ALIGN_EN defined to exercise the automatic alignment build.
// -----------------------------------------------------------------------------
module tb_deser_align;

  localparam int         W          = 8;
  localparam logic [7:0] COMMA      = 8'hBC;
  localparam int         LOCK_COUNT = 4;
  localparam int         TIMEOUT    = 16;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         DIN = 1'b0;
  logic         CE = 1'b0;
  logic         BITSLIP = 1'b0;
  logic [W-1:0] DOUT;
  logic         DVALID;
  logic         IS_COMMA;
  logic         LOCKED;
  logic [2:0]   SLIP_CNT;

  int checks   = 0;
  int failures = 0;
  bit checkEnable = 1'b0;

  deser_align #(
    .DATA_WIDTH (W),
    .COMMA      (COMMA),
    .LOCK_COUNT (LOCK_COUNT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .DIN      (DIN),
    .CE       (CE),
    .BITSLIP  (BITSLIP),
    .DOUT     (DOUT),
    .DVALID   (DVALID),
    .IS_COMMA (IS_COMMA),
    .LOCKED   (LOCKED),
    .SLIP_CNT (SLIP_CNT)
  );

  // 10-unit clock period.
  always #5 CLK = ~CLK;

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. The current word is a queue of received bits: a slip
  // throws away the oldest bit, and a word is released once eight bits are
  // collected. In the auto build the last eight bits received are also
  // compared against the comma while searching.
  // ---------------------------------------------------------------------------
  bit         wordQ[$];
  logic [7:0] expDout;
  logic       expDvalid;
  logic       expComma;
  logic       expLocked;
  logic [2:0] expSlip;
`ifdef DESER_AUTO_ALIGN_EN
  localparam int M_SEARCH = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCKED = 2;
  logic [7:0] hist;
  int         mState;
  int         mHit;
  int         mMiss;
`else
  bit         dropped;
`endif

  always @(posedge CLK or posedge RST) begin
    logic [7:0] v;
    if (RST) begin
      wordQ.delete();
      expDout   = 8'h00;
      expDvalid = 1'b0;
      expComma  = 1'b0;
      expLocked = 1'b0;
      expSlip   = 3'd0;
`ifdef DESER_AUTO_ALIGN_EN
      hist   = 8'h00;
      mState = M_SEARCH;
      mHit   = 0;
      mMiss  = 0;
`endif
    end else begin
      expDvalid = 1'b0;
      expComma  = 1'b0;
      if (CE === 1'b1) begin
`ifdef DESER_AUTO_ALIGN_EN
        hist = {hist[6:0], DIN};
        if (mState == M_SEARCH && hist == COMMA) begin
          expDout   = hist;
          expDvalid = 1'b1;
          expComma  = 1'b1;
          wordQ.delete();
          mHit   = 1;
          mMiss  = 0;
          mState = (LOCK_COUNT == 1) ? M_LOCKED : M_VERIFY;
        end else begin
          wordQ.push_back(DIN);
          if (wordQ.size() == W) begin
            v = 8'h00;
            foreach (wordQ[i]) v = {v[6:0], wordQ[i]};
            wordQ.delete();
            expDout   = v;
            expDvalid = 1'b1;
            expComma  = (v == COMMA);
            if (mState != M_SEARCH) begin
              if (v == COMMA) begin
                mMiss = 0;
                if (mState == M_VERIFY) begin
                  mHit++;
                  if (mHit == LOCK_COUNT) mState = M_LOCKED;
                end
              end else begin
                mMiss++;
                if (mMiss == TIMEOUT) begin
                  mState = M_SEARCH;
                  mHit   = 0;
                  mMiss  = 0;
                end
              end
            end
          end
        end
        expLocked = (mState == M_LOCKED);
`else
        wordQ.push_back(DIN);
        if (BITSLIP === 1'b1) begin
          dropped = wordQ.pop_front();
          expSlip = 3'((int'(expSlip) + 1) % W);
        end else if (wordQ.size() == W) begin
          v = 8'h00;
          foreach (wordQ[i]) v = {v[6:0], wordQ[i]};
          wordQ.delete();
          expDout   = v;
          expDvalid = 1'b1;
          expComma  = (v == COMMA);
        end
`endif
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (checkEnable) begin
      checkOutput("model_dvalid",   32'(DVALID),   32'(expDvalid));
      checkOutput("model_dout",     32'(DOUT),     32'(expDout));
      checkOutput("model_is_comma", 32'(IS_COMMA), 32'(expComma));
      checkOutput("model_locked",   32'(LOCKED),   32'(expLocked));
      checkOutput("model_slip_cnt", 32'(SLIP_CNT), 32'(expSlip));
    end
  end

  // Drive one cycle of inputs; returns 2 units after the edge that used them,
  // so the DUT outputs already reflect that edge.
  task automatic applyStimulus(input logic d, input logic ce, input logic bs);
    DIN     = d;
    CE      = ce;
    BITSLIP = bs;
    @(posedge CLK);
    #2;
  endtask

  task automatic applyReset();
    DIN     = 1'b0;
    CE      = 1'b0;
    BITSLIP = 1'b0;
    RST     = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RST = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) applyStimulus(b[i], 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] curByte;
    int         bitPos;
    int         cyc;
    int         strobes;
    int         firstStrobe;
    int         lastStrobe;
    logic       ce;
    logic       d;
    logic       bs;

    applyReset();
    checkEnable = 1'b1;

    // Reset state.
    checkOutput("reset_dout",     32'(DOUT),     32'h00);
    checkOutput("reset_dvalid",   32'(DVALID),   32'h0);
    checkOutput("reset_is_comma", 32'(IS_COMMA), 32'h0);
    checkOutput("reset_locked",   32'(LOCKED),   32'h0);
    checkOutput("reset_slip_cnt", 32'(SLIP_CNT), 32'h0);

    // Single comma word after reset.
    pat = 8'hBC;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(pat[i], 1'b1, 1'b0);
      if (i > 0) checkOutput("first_word_no_early_strobe", 32'(DVALID), 32'h0);
    end
    checkOutput("first_word_dvalid", 32'(DVALID),   32'h1);
    checkOutput("first_word_dout",   32'(DOUT),     32'hBC);
    checkOutput("first_word_comma",  32'(IS_COMMA), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("strobe_one_cycle", 32'(DVALID), 32'h0);
    checkOutput("dout_held",        32'(DOUT),   32'hBC);

`ifndef DESER_AUTO_ALIGN_EN
    // Comma stream three bits late, realigned by three slips.
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'($urandom_range(1)), 1'b1, 1'b1);
    checkOutput("slip_cnt_after_3", 32'(SLIP_CNT), 32'h3);
    strobes = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 7; i >= 0; i--) begin
        applyStimulus(pat[i], 1'b1, 1'b0);
        if (DVALID) begin
          strobes++;
          checkOutput("slip_dout",  32'(DOUT),     32'hBC);
          checkOutput("slip_comma", 32'(IS_COMMA), 32'h1);
        end
      end
    end
    checkOutput("slip_strobe_count", 32'(strobes), 32'h4);
`endif

    // Half-rate CE with a 5A stream; slip requests on idle cycles are ignored.
    applyReset();
    pat         = 8'h5A;
    cyc         = 0;
    strobes     = 0;
    firstStrobe = -1;
    lastStrobe  = -1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 7; i >= 0; i--) begin
        for (int h = 0; h < 2; h++) begin
          if (h == 0) applyStimulus(pat[i], 1'b1, 1'b0);
          else        applyStimulus(1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
          cyc++;
          if (DVALID) begin
            strobes++;
            checkOutput("ce_half_dout", 32'(DOUT), 32'h5A);
            if (firstStrobe < 0) firstStrobe = cyc;
            else checkOutput("ce_half_spacing", 32'(cyc - lastStrobe), 32'd16);
            lastStrobe = cyc;
          end
        end
      end
    end
    checkOutput("ce_half_first_strobe", 32'(firstStrobe), 32'd15);
    checkOutput("ce_half_strobes",      32'(strobes),     32'd3);
    checkOutput("ce_half_slip_cnt",     32'(SLIP_CNT),    32'd0);

`ifdef DESER_AUTO_ALIGN_EN
    begin
      int  bitIdx;
      int  commaStrobes;
      int  firstCommaBit;
      int  lockAt;
      int  nonComma;
      int  fallAt;
      bit  lockSeen;
      logic [7:0] expNext;

      // Alternating BC/5A stream five bits off the reset boundary.
      applyReset();
      bitIdx        = 0;
      commaStrobes  = 0;
      firstCommaBit = -1;
      lockAt        = -1;
      lockSeen      = 1'b0;
      expNext       = 8'h5A;
      for (int i = 0; i < 5; i++) begin
        applyStimulus(1'b0, 1'b1, 1'($urandom_range(1)));
        bitIdx++;
      end
      for (int p = 0; p < 13; p++) begin
        pat = (p % 2 == 0) ? 8'hBC : 8'h5A;
        for (int i = 7; i >= 0; i--) begin
          applyStimulus(pat[i], 1'b1, 1'b0);
          bitIdx++;
          if (DVALID && IS_COMMA) begin
            commaStrobes++;
            if (firstCommaBit < 0) firstCommaBit = bitIdx;
          end
          if (DVALID && lockSeen) begin
            checkOutput("auto_alternation", 32'(DOUT), 32'(expNext));
            expNext = (expNext == 8'hBC) ? 8'h5A : 8'hBC;
          end
          if (LOCKED && !lockSeen) begin
            lockSeen = 1'b1;
            lockAt   = commaStrobes;
            checkOutput("auto_lock_on_comma_strobe", 32'(DVALID && IS_COMMA), 32'h1);
          end
        end
      end
      checkOutput("auto_first_comma_bit", 32'(firstCommaBit), 32'd13);
      checkOutput("auto_lock_at_comma",   32'(lockAt),        32'd4);
      checkOutput("auto_locked_before_zeros", 32'(LOCKED),   32'h1);

      // Loss of lock on an all-zero stream.
      nonComma = 0;
      fallAt   = -1;
      for (int k = 0; k < 20; k++) begin
        for (int i = 0; i < 8; i++) begin
          applyStimulus(1'b0, 1'b1, 1'b0);
          if (DVALID && !IS_COMMA) nonComma++;
          if (!LOCKED && fallAt < 0) fallAt = nonComma;
        end
      end
      checkOutput("auto_unlock_after", 32'(fallAt), 32'd16);

      // Reacquire once commas return, at an arbitrary bit offset.
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) sendByte(8'hBC);
      checkOutput("auto_relock", 32'(LOCKED), 32'h1);
    end
`endif

    // Asynchronous reset four bits into a word.
    applyReset();
    sendByte(8'hBC);
    pat = 8'hD3;
    for (int i = 7; i >= 4; i--) applyStimulus(pat[i], 1'b1, 1'b0);
    #1;
    RST = 1'b1;
    #1;
    checkOutput("async_rst_dout",     32'(DOUT),     32'h00);
    checkOutput("async_rst_dvalid",   32'(DVALID),   32'h0);
    checkOutput("async_rst_is_comma", 32'(IS_COMMA), 32'h0);
    checkOutput("async_rst_locked",   32'(LOCKED),   32'h0);
    checkOutput("async_rst_slip_cnt", 32'(SLIP_CNT), 32'h0);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(pat[i], 1'b1, 1'b0);
      if (i > 0) checkOutput("post_rst_no_early_strobe", 32'(DVALID), 32'h0);
    end
    checkOutput("post_rst_dvalid", 32'(DVALID), 32'h1);
    checkOutput("post_rst_dout",   32'(DOUT),   32'hA5);

    // Randomized traffic checked by the model.
    applyReset();
    bitPos  = 8;
    curByte = 8'h00;
    for (int n = 0; n < 1500; n++) begin
      ce = ($urandom_range(99) < 78);
      bs = ($urandom_range(99) < 12);
      d  = 1'($urandom_range(1));
`ifdef DESER_AUTO_ALIGN_EN
      if (ce) begin
        if (bitPos == 8) begin
          case ($urandom_range(9))
            0, 1, 2, 3: curByte = 8'hBC;
            4, 5, 6:    curByte = 8'h5A;
            default:    curByte = 8'($urandom_range(255));
          endcase
          bitPos = 0;
        end
        d = curByte[7 - bitPos];
        bitPos++;
      end
`endif
      applyStimulus(d, ce, bs);
    end

    @(negedge CLK);
    checkEnable = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
